// File: rtl/mips_pkg.sv
// RegDst encodings, fixed register indices and default widths shared by the
// write-back destination queue and the control unit.
package mips_pkg;

  localparam int ADDR_W_DEF = 5;

  localparam logic [2:0] REGDST_RT = 3'b000;
  localparam logic [2:0] REGDST_RD = 3'b001;
  localparam logic [2:0] REGDST_RA = 3'b010;
  localparam logic [2:0] REGDST_SP = 3'b011;
  localparam logic [2:0] REGDST_FP = 3'b100;

  localparam int RA = 31;
  localparam int SP = 29;
  localparam int FP = 30;

endpackage

// File: rtl/regdst_fifo.sv
// Generic DEPTH x W synchronous FIFO; head visible the cycle after the push edge.
// Push is ignored when full and pop when empty; the head holds its last popped value while empty.
module regdst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [W-1:0]     r_last;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  // While empty, show the most recently popped entry rather than a stale slot.
  assign o_head_dat = o_empty ? r_last : r_mem[r_head];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_last  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_dat;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_last <= r_mem[r_head];
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regdst_queue.sv
// Decodes RegDst into a register index, queues pending write-backs and tracks per-register busy.
// Entry reaches wb_dest one cycle after the push edge; sel_ready = !full, independent of wb_ready.
module regdst_queue
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4,
  parameter int RA_IDX = RA,
  parameter int SP_IDX = SP,
  parameter int FP_IDX = FP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  input  logic [SEL_W-1:0]       reg_dst,
  input  logic [ADDR_W-1:0]      in_rt,
  input  logic [ADDR_W-1:0]      in_rd,
  output logic                   sel_err,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [ADDR_W-1:0]      wb_dest,
  input  logic [ADDR_W-1:0]      q_rs,
  input  logic [ADDR_W-1:0]      q_rt,
  output logic                   rs_busy,
  output logic                   rt_busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic [ADDR_W-1:0] w_idx;
  logic              w_legal;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic [CNT_W-1:0]  r_pend [NREG];
  logic              r_sel_err;

  always_comb begin
    w_legal = 1'b1;
    w_idx   = '0;
    case (reg_dst)
      SEL_W'(REGDST_RT): w_idx = in_rt;
      SEL_W'(REGDST_RD): w_idx = in_rd;
      SEL_W'(REGDST_RA): w_idx = ADDR_W'(RA_IDX);
      SEL_W'(REGDST_SP): w_idx = ADDR_W'(SP_IDX);
      SEL_W'(REGDST_FP): w_idx = ADDR_W'(FP_IDX);
      default:           w_legal = 1'b0;
    endcase
  end

  assign sel_ready = !w_full;
  assign wb_valid  = !w_empty;
  assign w_accept  = sel_valid && !w_full && !flush;
  assign w_push    = w_accept && w_legal;
  assign w_pop     = wb_valid && wb_ready && !flush;
  assign sel_err   = r_sel_err;

  regdst_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_flush    (flush),
    .i_push     (w_push),
    .i_push_dat (w_idx),
    .i_pop      (w_pop),
    .o_head_dat (wb_dest),
    .o_count    (count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Register 0 is hardwired, so it never becomes busy.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_push) w_inc[w_idx]   = 1'b1;
    if (w_pop)  w_dec[wb_dest] = 1'b1;
    w_inc[0] = 1'b0;
    w_dec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i])      r_pend[i] <= r_pend[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i]) r_pend[i] <= r_pend[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sel_err <= 1'b0;
    else        r_sel_err <= w_accept && !w_legal;
  end

  assign rs_busy = (r_pend[q_rs] != '0);
  assign rt_busy = (r_pend[q_rt] != '0);

endmodule

// File: tb/tb_regdst_queue.sv
// Directed bench for regdst_queue: a driver queues expected write-back indices,
// an independent monitor pops and compares them whenever the DUT hands one over.
module tb_regdst_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       sel_valid;
  logic       sel_ready;
  logic [2:0] reg_dst;
  logic [4:0] in_rt;
  logic [4:0] in_rd;
  logic       sel_err;
  logic       wb_valid;
  logic       wb_ready;
  logic [4:0] wb_dest;
  logic [4:0] q_rs;
  logic [4:0] q_rt;
  logic       rs_busy;
  logic       rt_busy;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  regdst_queue dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .reg_dst   (reg_dst),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .sel_err   (sel_err),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_dest   (wb_dest),
    .q_rs      (q_rs),
    .q_rt      (q_rt),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .count     (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted write-back must match the oldest expected index.
  always @(negedge clk) begin
    if (reset && !flush && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got %0d expected no write-back", wb_dest);
      end else begin
        check("wb_dest", 32'(wb_dest), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] code, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] exp_idx, input bit exp_push);
    sel_valid = 1'b1;
    reg_dst   = code;
    in_rt     = rt;
    in_rd     = rd;
    if (exp_push) exp_q.push_back(exp_idx);
    tick();
    sel_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; sel_valid = 1'b0; reg_dst = 3'd0;
    in_rt = 5'd0; in_rd = 5'd0; wb_ready = 1'b0; q_rs = 5'd31; q_rt = 5'd8;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check("rst_sel_ready", 32'(sel_ready), 1);
    check("rst_wb_valid",  32'(wb_valid),  0);
    check("rst_count",     32'(count),     0);
    check("rst_wb_dest",   32'(wb_dest),   0);
    check("rst_rs_busy",   32'(rs_busy),   0);
    check("rst_rt_busy",   32'(rt_busy),   0);
    check("rst_sel_err",   32'(sel_err),   0);

    // rt, rd and $ra back to back with write-back stalled
    push(3'b000, 5'd8, 5'd0, 5'd8,  1);
    push(3'b001, 5'd0, 5'd9, 5'd9,  1);
    push(3'b010, 5'd0, 5'd0, 5'd31, 1);
    check("fill3_count",   32'(count),    3);
    check("fill3_wb_dest", 32'(wb_dest),  8);
    check("fill3_wb_vld",  32'(wb_valid), 1);
    q_rs = 5'd31; q_rt = 5'd9;
    #1;
    check("fill3_rs_busy_ra", 32'(rs_busy), 1);
    check("fill3_rt_busy_rd", 32'(rt_busy), 1);

    wb_ready = 1'b1;
    repeat (3) tick();
    wb_ready = 1'b0;
    check("drain_count",     32'(count),    0);
    check("drain_wb_valid",  32'(wb_valid), 0);
    check("drain_hold_dest", 32'(wb_dest),  31);
    check("drain_rs_busy",   32'(rs_busy),  0);
    check("drain_rt_busy",   32'(rt_busy),  0);
    check("drain_sb_empty",  32'(exp_q.size()), 0);

    // Fill to DEPTH, try a fifth push, then push+pop across the pointer wrap
    for (int i = 1; i <= 4; i++) push(3'b000, 5'(i), 5'd0, 5'(i), 1);
    check("full_count",     32'(count),     4);
    check("full_sel_ready", 32'(sel_ready), 0);
    wb_ready = 1'b0;
    push(3'b001, 5'd0, 5'd7, 5'd7, 0);
    check("full_ignored_count", 32'(count), 4);
    wb_ready = 1'b1;
    repeat (2) tick();
    wb_ready = 1'b0;
    check("half_count", 32'(count), 2);
    wb_ready = 1'b1;
    push(3'b000, 5'd10, 5'd0, 5'd10, 1);
    wb_ready = 1'b0;
    check("pushpop_count", 32'(count),   2);
    check("pushpop_head",  32'(wb_dest), 4);
    wb_ready = 1'b1;
    repeat (2) tick();
    wb_ready = 1'b0;
    check("wrap_count", 32'(count),   0);
    check("wrap_last",  32'(wb_dest), 10);

    // Duplicate pending writes and index 0
    push(3'b001, 5'd0, 5'd5, 5'd5, 1);
    push(3'b001, 5'd0, 5'd5, 5'd5, 1);
    q_rs = 5'd5;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    #1;
    check("dup_rs_busy_one_left", 32'(rs_busy), 1);
    check("dup_count",            32'(count),   1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("dup_rs_busy_clear", 32'(rs_busy), 0);
    push(3'b000, 5'd0, 5'd0, 5'd0, 1);
    q_rt = 5'd0;
    #1;
    check("r0_rt_busy", 32'(rt_busy), 0);
    check("r0_count",   32'(count),   1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("r0_drained", 32'(count), 0);

    // Illegal code: one-cycle error pulse, nothing queued
    check("pre_err_sel_err", 32'(sel_err), 0);
    push(3'b110, 5'd3, 5'd4, 5'd0, 0);
    check("illegal_sel_err", 32'(sel_err), 1);
    check("illegal_count",   32'(count),   0);
    tick();
    check("illegal_err_pulse_end", 32'(sel_err), 0);

    // Flush wins over a simultaneous push and suppresses the error
    push(3'b000, 5'd6, 5'd0, 5'd6, 1);
    check("preflush_count", 32'(count), 1);
    flush = 1'b1;
    exp_q.delete();
    push(3'b000, 5'd7, 5'd0, 5'd7, 0);
    flush = 1'b0;
    check("flush_count",    32'(count),    0);
    check("flush_wb_valid", 32'(wb_valid), 0);
    q_rs = 5'd6; q_rt = 5'd7;
    #1;
    check("flush_rs_busy", 32'(rs_busy), 0);
    check("flush_rt_busy", 32'(rt_busy), 0);
    flush = 1'b1;
    push(3'b111, 5'd0, 5'd0, 5'd0, 0);
    flush = 1'b0;
    check("flush_err_suppressed", 32'(sel_err),   0);
    check("flush_sel_ready",      32'(sel_ready), 1);

    // Asynchronous reset in the middle of a cycle with entries queued
    push(3'b000, 5'd11, 5'd0, 5'd11, 1);
    push(3'b000, 5'd12, 5'd0, 5'd12, 1);
    q_rs = 5'd11;
    #1;
    check("prereset_rs_busy", 32'(rs_busy), 1);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_wb_valid",  32'(wb_valid),  0);
    check("async_rst_count",     32'(count),     0);
    check("async_rst_sel_ready", 32'(sel_ready), 1);
    check("async_rst_wb_dest",   32'(wb_dest),   0);
    check("async_rst_rs_busy",   32'(rs_busy),   0);
    tick();
    reset = 1'b1;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("post_rst_wb_valid", 32'(wb_valid), 0);
    check("post_rst_count",    32'(count),    0);
    check("final_sb_empty",    32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regdst_queue.md
Name: regdst_queue

Overview:
- Parametrised successor to the write-back destination selector in the multicycle MIPS datapath.
- Decodes the RegDst code into a register index (rt, rd, $ra, $sp, $fp/30) and queues it in a small FIFO of pending register-file writes.
- Tracks a per-register pending-write scoreboard so the control unit can detect RAW hazards on rs/rt.
- Sits between the control unit (issue side) and the register-file write port (write-back side).

Parameters:
- ADDR_W, 5, register index width; register file has 2**ADDR_W entries.
- SEL_W, 3, RegDst code width.
- DEPTH, 4, pending-write FIFO depth; power of two, 2 or greater.
- RA_IDX, 31, index for code 3'b010.
- SP_IDX, 29, index for code 3'b011.
- FP_IDX, 30, index for code 3'b100.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue and scoreboard.
- sel_valid  in  1  issue request.
- sel_ready  out  1  queue can accept; equals !full.
- reg_dst  in  SEL_W  destination select code.
- in_rt  in  ADDR_W  instruction rt field.
- in_rd  in  ADDR_W  instruction rd field.
- sel_err  out  1  registered one-cycle pulse on an illegal code.
- wb_valid  out  1  queue non-empty; head is valid.
- wb_ready  in  1  register file consumes the head this cycle.
- wb_dest  out  ADDR_W  head destination index.
- q_rs  in  ADDR_W  hazard query index A.
- q_rt  in  ADDR_W  hazard query index B.
- rs_busy  out  1  q_rs has at least one pending write (combinational).
- rt_busy  out  1  q_rt has at least one pending write (combinational).
- count  out  clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Decode:
  - 000 -> in_rt; 001 -> in_rd; 010 -> RA_IDX; 011 -> SP_IDX; 100 -> FP_IDX.
  - Codes 101-111 are illegal: no push; sel_err pulses high the following cycle.
  - An illegal code raises sel_err only when sel_valid && sel_ready.
  - Decoded indices are zero-extended or truncated to ADDR_W; there is no 32-bit output.
- Push: occurs when sel_valid && sel_ready && legal code.
  - The entry is written at the tail pointer.
  - The pending counter for that index increments.
- Pop: occurs when wb_valid && wb_ready.
  - The head pointer advances.
  - The pending counter for the popped index decrements.
- Latency:
  - A pushed entry appears on wb_dest/wb_valid the cycle after the push edge when the queue was empty; there is no bypass.
  - The scoreboard reflects a push from the next cycle.
- Pointers:
  - Head and tail are clog2(DEPTH) wide and wrap modulo DEPTH.
  - count is held as an explicit register.
- Full and empty:
  - When count == DEPTH, sel_ready = 0 and sel_valid is ignored; sel_ready does not depend on wb_ready.
  - When count == 0, wb_valid = 0, wb_ready is ignored, and wb_dest holds its last value (0 after reset).
- Simultaneous push and pop (not full):
  - count is unchanged and both pointers advance.
  - If push and pop target the same index, that pending counter is unchanged.
- Pending counters:
  - One counter per register, each clog2(DEPTH)+1 bits wide.
  - Busy means counter != 0.
  - Index 0 is never counted, so rs_busy/rt_busy are always 0 for index 0; index-0 entries are still queued and popped.
- Flush:
  - Synchronous; takes priority over push and pop in the same cycle.
  - Clears pointers, count and all pending counters.
  - Suppresses sel_err for that cycle.
- Reset (reset = 0, asynchronous):
  - Pointers, count and all pending counters are cleared.
  - sel_ready = 1, wb_valid = 0, wb_dest = 0, sel_err = 0, rs_busy = 0, rt_busy = 0.
  - Reset asserted mid-operation discards all queued entries immediately; no write-back is emitted.
- Invariants:
  - Sum of all pending counters equals count minus the number of queued index-0 entries.
  - count never exceeds DEPTH.

Decomposition:
- Shared package (mips_pkg):
  - REGDST_RT = 3'b000, REGDST_RD = 3'b001, REGDST_RA = 3'b010, REGDST_SP = 3'b011, REGDST_FP = 3'b100.
  - Register index constants: RA = 31, SP = 29, FP = 30.
  - ADDR_W default.
- One sub-module: regdst_fifo, a generic DEPTH x ADDR_W synchronous FIFO with count, full and empty.
- The top level holds the decoder, the scoreboard counters and error logic.

Test Plan:
- Reset then idle -> sel_ready = 1, wb_valid = 0, count = 0, wb_dest = 0, rs_busy = rt_busy = 0.
- Push codes 000 (rt = 8), 001 (rd = 9), 010 on consecutive cycles, wb_ready = 0 -> count = 3, wb_dest = 8; q_rs = 31 gives rs_busy = 1.
- Then pop three cycles -> wb_dest sequence 8, 9, 31; count = 0; all busy flags clear.
- Push 4 entries (DEPTH = 4) -> sel_ready = 0. A 5th sel_valid is ignored (count stays 4). Push+pop in the same cycle at count = 2 keeps count = 2 and wraps the tail pointer.
- Push rd = 5 twice, pop once -> rs_busy for q_rs = 5 stays 1. Pop again -> rs_busy = 0. Push rt = 0 -> rt_busy for q_rt = 0 stays 0, count = 1.
- reg_dst = 3'b110 with sel_valid -> no push, sel_err = 1 for exactly one cycle.
- flush = 1 with a simultaneous push -> count = 0, no error pulse.
- Assert reset mid-queue -> wb_valid drops asynchronously and state is cleared.
